sram_axi_bridge: RTL and testbench

Converts the CPU core's sram-like request interface (req/addr_ok/data_ok) into a single-ID AXI master. It sits directly downstream of the CPU top, replacing the direct inst/data SRAM connections. An external arbiter merges instruction and data traffic onto this one request port. The block allows at most one outstanding transaction.

---
 rtl/sram_axi_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: converts the CPU's sram-like request port (req/addr_ok/data_ok)
// into a single-ID AXI master with at most one outstanding transaction.
//
// Optional feature macro: AXI_BRIDGE_POSTED_WRITE_EN
//   Defined   : writes are posted. data_ok pulses the cycle after acceptance, and a background
//               sub-FSM finishes AW/W/B. New requests are held off (addr_ok low) until that
//               write's B handshake completes, so reads never overtake an earlier write.
//   Undefined : writes block until the B handshake, then data_ok pulses.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   req, wr, size, wstrb, addr, wdata request side (sram-like)
//   addr_ok, data_ok, rdata           request handshake, completion pulse, read data
//   araddr/arsize/arvalid/arready     AXI read address channel
//   axi_rdata/rvalid/rready           AXI read data channel
//   awaddr/awsize/awvalid/awready     AXI write address channel
//   awdata/awstrb/wvalid/wready       AXI write data channel
//   bvalid/bready                     AXI write response channel
// Fixed AXI fields (id, len, burst, lock, cache, prot, wlast) are tied off at integration.
module sram_axi_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  // sram-like request side
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [DATA_W-1:0]     rdata,
  // AXI read address
  output logic [ADDR_W-1:0]     araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI read data
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic                  rvalid,
  output logic                  rready,
  // AXI write address
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI write data
  output logic [DATA_W-1:0]     awdata,
  output logic [DATA_W/8-1:0]   awstrb,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI write response
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAr,
    StRdR,
    StWrAwW,
    StWrB
  } state_e;

  state_e state_q, state_d;

  // Holds addr_ok low from reset until the first clock edge after release.
  logic rst_hold_q;

  // Captured request. The direction is not stored: it is encoded in which branch the FSM takes.
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              data_ok_q, data_ok_d;

  // AW and W complete independently; each flag marks its channel as finished.
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic       accept;
  logic [1:0] size_legal;
  logic       wr_aw_phase;
  logic       wr_b_phase;

  // size 3 is not a legal request size; it is issued as a word access.
  assign size_legal = (size == 2'd3) ? 2'd2 : size;

`ifdef AXI_BRIDGE_POSTED_WRITE_EN
  typedef enum logic [1:0] {
    WbIdle,
    WbAwW,
    WbB
  } wb_state_e;

  wb_state_e wb_q, wb_d;
  logic      wb_busy;

  assign wb_busy     = (wb_q != WbIdle);
  assign addr_ok     = (state_q == StIdle) && !rst_hold_q && !wb_busy;
  assign wr_aw_phase = (wb_q == WbAwW);
  assign wr_b_phase  = (wb_q == WbB);
`else
  assign addr_ok     = (state_q == StIdle) && !rst_hold_q;
  assign wr_aw_phase = (state_q == StWrAwW);
  assign wr_b_phase  = (state_q == StWrB);
`endif

  assign accept = req && addr_ok;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      rst_hold_q <= 1'b1;
      rdata_q    <= '0;
      data_ok_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_hold_q <= 1'b0;
      rdata_q    <= rdata_d;
      data_ok_q  <= data_ok_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      size_q  <= size_legal;
      addr_q  <= addr;
      wstrb_q <= wstrb;
      wdata_q <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    data_ok_d = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    // Write channel progress, shared by the blocking FSM and the posted sub-FSM.
    if (accept && wr) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else if (wr_aw_phase) begin
      aw_done_d = aw_done_q | awready;
      w_done_d  = w_done_q | wready;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!wr) begin
            state_d = StRdAr;
          end else begin
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
            // Posted: complete toward the CPU now; the sub-FSM drives AW/W/B.
            data_ok_d = 1'b1;
`else
            state_d = StWrAwW;
`endif
          end
        end
      end
      StRdAr: begin
        if (arready) state_d = StRdR;
      end
      StRdR: begin
        if (rvalid) begin
          rdata_d   = axi_rdata;
          data_ok_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StWrAwW: begin
        if (aw_done_d && w_done_d) state_d = StWrB;
      end
      StWrB: begin
        if (bvalid) begin
          data_ok_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef AXI_BRIDGE_POSTED_WRITE_EN
  // ---------------------------------------------------------------------------
  // Background write sub-FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_q <= WbIdle;
    end else begin
      wb_q <= wb_d;
    end
  end

  always_comb begin
    wb_d = wb_q;
    unique case (wb_q)
      WbIdle: begin
        if (accept && wr) wb_d = WbAwW;
      end
      WbAwW: begin
        if (aw_done_d && w_done_d) wb_d = WbB;
      end
      WbB: begin
        if (bvalid) wb_d = WbIdle;
      end
      default: wb_d = WbIdle;
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arvalid = (state_q == StRdAr);
  assign rready  = (state_q == StRdR);

  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign awvalid = wr_aw_phase && !aw_done_q;
  assign awdata  = wdata_q;
  assign awstrb  = wstrb_q;
  assign wvalid  = wr_aw_phase && !w_done_q;
  assign bready  = wr_b_phase;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Testbench for sram_axi_bridge: directed latency/reset scenarios plus randomized traffic.
// A memory-model AXI slave with programmable ready/valid delays answers the bridge; accepted
// requests feed scoreboard queues that are checked at AR/AW handshakes and at data_ok.
module tb_sram_axi_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [1:0]    size = 2'd0;
  logic [SW-1:0] wstrb = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          addr_ok, data_ok;
  logic [DW-1:0] rdata;
  logic [AW-1:0] araddr, awaddr;
  logic [2:0]    arsize, awsize;
  logic          arvalid, rready, awvalid, wvalid, bready;
  logic [DW-1:0] awdata;
  logic [SW-1:0] awstrb;
  logic          arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [DW-1:0] axi_rdata = '0;

  sram_axi_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .awdata(awdata), .awstrb(awstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_axi[$];   // expected AXI address/data beats, in issue order
  exp_t exp_resp[$];  // expected data_ok responses (data = read data for reads)

  logic [DW-1:0] ref_mem[int unsigned];
  logic [DW-1:0] slv_mem[int unsigned];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event with nothing expected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < int'(SW); b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // AXI slave model
  // ---------------------------------------------------------------------------
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [DW-1:0] r_q[$];
  bit aw_got = 0, w_got = 0, b_pend = 0;
  logic [AW-1:0] s_awaddr;
  logic [2:0]    s_awsize;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  int b_hs_cyc = -1;
  int order_viol = 0;

  initial begin
    exp_t e;
    int unsigned k;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        r_q.delete(); aw_got = 0; w_got = 0; b_pend = 0;
      end else begin
        arready = arvalid && (ar_wait >= ar_dly);
        ar_wait = arvalid ? ar_wait + 1 : 0;
        if (r_q.size() > 0) begin
          rvalid = (r_wait >= r_dly);
          axi_rdata = rvalid ? r_q[0] : DW'($urandom);
          r_wait++;
        end else begin
          rvalid = 0; r_wait = 0; axi_rdata = DW'($urandom);
        end
        awready = awvalid && (aw_wait >= aw_dly);
        aw_wait = awvalid ? aw_wait + 1 : 0;
        wready = wvalid && (w_wait >= w_dly);
        w_wait = wvalid ? w_wait + 1 : 0;
        if (b_pend) begin
          bvalid = (b_wait >= b_dly);
          b_wait++;
        end else begin
          bvalid = 0; b_wait = 0;
        end
      end

      @(negedge clk);
      if (resetn) begin
        if (arvalid && (b_pend || aw_got || w_got)) order_viol++;
        if (arvalid && arready) begin
          if (exp_axi.size() == 0) fail_now("ar_unexpected");
          else begin
            e = exp_axi.pop_front();
            check("ar_is_read", e.wr, 0);
            check("araddr", araddr, e.addr);
            check("arsize", arsize, e.size);
          end
          k = araddr >> 2;
          r_q.push_back(slv_mem.exists(k) ? slv_mem[k] : '0);
        end
        if (rvalid && rready) begin
          void'(r_q.pop_front());
          r_wait = 0;
        end
        if (bvalid && bready) begin
          b_pend = 0;
          b_hs_cyc = cyc;
        end
        if (awvalid && awready) begin
          aw_got = 1; s_awaddr = awaddr; s_awsize = awsize;
        end
        if (wvalid && wready) begin
          w_got = 1; s_wdata = awdata; s_wstrb = awstrb;
        end
        if (aw_got && w_got) begin
          if (exp_axi.size() == 0) fail_now("aw_unexpected");
          else begin
            e = exp_axi.pop_front();
            check("aw_is_write", e.wr, 1);
            check("awaddr", s_awaddr, e.addr);
            check("awsize", s_awsize, e.size);
            check("wdata", s_wdata, e.data);
            check("wstrb", s_wstrb, e.strb);
          end
          k = s_awaddr >> 2;
          slv_mem[k] = merge(slv_mem.exists(k) ? slv_mem[k] : '0, s_wdata, s_wstrb);
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: push on acceptance, pop and compare on data_ok
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    int unsigned k;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (data_ok) begin
          if (exp_resp.size() == 0) fail_now("data_ok_unexpected");
          else begin
            e = exp_resp.pop_front();
            if (!e.wr) check("rdata", rdata, e.data);
          end
        end
        if (req && addr_ok) begin
          e.wr = wr;
          e.addr = addr;
          e.size = (size == 2'd3) ? 3'd2 : {1'b0, size};
          e.strb = wstrb;
          e.data = wdata;
          exp_axi.push_back(e);
          k = addr >> 2;
          if (wr) ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : '0, wdata, wstrb);
          else e.data = ref_mem.exists(k) ? ref_mem[k] : '0;
          exp_resp.push_back(e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called and returning at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [1:0] s,
                       input logic [SW-1:0] st, input logic [DW-1:0] d, input bit keep,
                       output int t, output bit dok_at_accept);
    req = 1; wr = w; addr = a; size = s; wstrb = st; wdata = d;
    t = -1;
    dok_at_accept = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (addr_ok) begin
        t = cyc;
        dok_at_accept = data_ok;
        break;
      end
    end
    if (t < 0) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) begin
      req = 0; addr = AW'($urandom); wdata = DW'($urandom);
    end
  endtask

  task automatic wait_dok(output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (data_ok) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("data_ok_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_resp.size() != 0 || exp_axi.size() != 0 || !addr_ok) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", (exp_resp.size() == 0 && exp_axi.size() == 0 && addr_ok) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t, t2, tdok, n;
    bit dk;
    logic [4:1] av, wv, dv;
    bit w, keep;
    logic [AW-1:0] a;

    ref_mem[32'h1c000000 >> 2] = 32'hdeadbeef;
    slv_mem[32'h1c000000 >> 2] = 32'hdeadbeef;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_capture", {araddr, awdata, awstrb, arsize}, 0);
    @(posedge clk);
    #2;
    resetn = 1;
    @(negedge clk);
    check("addr_ok_first_cycle", addr_ok, 0);
    @(negedge clk);
    check("addr_ok_after_hold", addr_ok, 1);
    @(posedge clk);
    #1;

    // Read with arready at T+2, rvalid at T+4
    ar_dly = 1; r_dly = 1;
    issue(0, 32'h1c000000, 2'd2, '0, '0, 0, t, dk);
    check("t1_arvalid", arvalid, 1);
    check("t1_arsize", arsize, 3'd2);
    check("t1_araddr", araddr, 32'h1c000000);
    wait_dok(tdok);
    check("rd_latency", tdok - t, 5);
    check("rd_single_pulse", data_ok, 0);
    check("rd_rdata_hold", rdata, 32'hdeadbeef);
    ar_dly = 0; r_dly = 0;
    drain();

    // Write with awready at T+1, wready at T+3
    aw_dly = 0; w_dly = 2; b_dly = 0;
    issue(1, 32'h1c000013, 2'd0, 4'b1000, 32'h11223344, 0, t, dk);
    for (int k = 1; k <= 4; k++) begin
      av[k] = awvalid; wv[k] = wvalid; dv[k] = data_ok;
      @(posedge clk);
      #1;
    end
    check("wr_awvalid_shape", av, 4'b0001);
    check("wr_wvalid_shape", wv, 4'b0111);
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
    check("wr_posted_dok", dv, 4'b0001);
`else
    check("wr_no_early_dok", dv, 4'b0000);
    wait_dok(tdok);
    check("wr_dok_after_b", tdok, b_hs_cyc + 1);
`endif
    w_dly = 0;
    drain();

    // Back-to-back reads with req held high, zero-wait slave
    issue(0, 32'h1c000010, 2'd2, '0, '0, 1, t, dk);
    issue(0, 32'h1c000000, 2'd1, '0, '0, 0, t2, dk);
    check("b2b_accept_gap", t2 - t, 3);
    check("b2b_dok_same_cycle", dk, 1);
    drain();

    // Zero-wait write
    issue(1, 32'h1c000020, 2'd2, 4'hf, 32'hcafef00d, 0, t, dk);
    for (int k = 1; k <= 3; k++) begin
      av[k] = awvalid; wv[k] = wvalid; dv[k] = data_ok;
      @(posedge clk);
      #1;
    end
    check("zw_awvalid", av[3:1], 3'b001);
    check("zw_wvalid", wv[3:1], 3'b001);
`ifdef AXI_BRIDGE_POSTED_WRITE_EN
    check("zw_dok", dv[3:1], 3'b001);
`else
    check("zw_dok", dv[3:1], 3'b100);
`endif
    drain();

    // Reset while arvalid is high
    ar_dly = 20;
    issue(0, 32'h1c000004, 2'd2, '0, '0, 0, t, dk);
    @(posedge clk);
    #2;
    check("abort_arvalid_before", arvalid, 1);
    resetn = 0;
    #1;
    check("abort_arvalid_async", arvalid, 0);
    check("abort_addr_ok_in_reset", addr_ok, 0);
    exp_resp.delete();
    exp_axi.delete();
    repeat (2) @(posedge clk);
    #2;
    resetn = 1;
    @(negedge clk);
    check("abort_addr_ok_first_cycle", addr_ok, 0);
    @(negedge clk);
    check("abort_addr_ok_after", addr_ok, 1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_ok) n++;
    end
    check("abort_no_dok", n, 0);
    ar_dly = 0;
    @(posedge clk);
    #1;

`ifdef AXI_BRIDGE_POSTED_WRITE_EN
    // Posted write followed by a read, B delayed 5 cycles
    b_dly = 5;
    issue(1, 32'h1c000030, 2'd2, 4'hf, 32'h0badf00d, 1, t, dk);
    check("posted_dok_t1", data_ok, 1);
    issue(0, 32'h1c000030, 2'd2, '0, '0, 0, t2, dk);
    check("posted_rd_after_b", t2, b_hs_cyc + 1);
    b_dly = 0;
    drain();
`endif

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      keep = (i == 149) ? 1'b0 : 1'($urandom_range(0, 1));
      a = 32'h1c000000 + AW'($urandom_range(0, 15) * 4) + AW'($urandom_range(0, 3));
      issue(w, a, 2'($urandom_range(0, 3)), SW'($urandom), DW'($urandom), keep, t, dk);
      if (!keep) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    req = 0;
    drain();

    check("no_read_during_write", order_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
